// File: rtl/fetch_pc_unit_pkg.sv
// Shared CPU constants for the fetch stage: reset vector, FSM encoding and
// word-alignment helper.
package fetch_pc_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StPend = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_incr.sv
// Adder pair for the fetch stage: next sequential fetch address and the
// link address of the instruction in decode.
module pc_incr (
  input  logic [31:0] pc_fetch_i,
  input  logic [31:0] pc_decode_i,
  output logic [31:0] fetch_plus4_o,
  output logic [31:0] decode_plus8_o
);

  // Both sums wrap modulo 2^32 by construction.
  assign fetch_plus4_o  = pc_fetch_i + 32'd4;
  assign decode_plus8_o = pc_decode_i + 32'd8;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generation with one branch delay slot, stall hold, and a pending
// redirect slot for branches resolved while the pipeline is stalled.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        take_branch,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  output logic [31:0] pc_id,
  output logic [31:0] pc_id_plus8,
  output logic        valid_id,
  output logic        misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;
  logic [31:0]  pc_id_q, pc_id_d;
  logic         valid_id_q, valid_id_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  pc_plus4;
  logic         target_unaligned;

  pc_incr u_pc_incr (
    .pc_fetch_i     (pc_q),
    .pc_decode_i    (pc_id_q),
    .fetch_plus4_o  (pc_plus4),
    .decode_plus8_o (pc_id_plus8)
  );

  assign target_unaligned = |branch_target[1:0];

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      pc_id_q    <= '0;
      valid_id_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pc_id_q    <= pc_id_d;
      valid_id_q <= valid_id_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StBoot:  state_d = StRun;
      StRun:   if (stall && take_branch) state_d = StPend;
      StPend:  if (!stall) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // take_branch is ignored in StBoot and StPend: in StPend the held decode
  // stage keeps re-asserting the same branch that is already captured.
  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pc_id_d    = pc_id_q;
    valid_id_d = valid_id_q;
    misalign_d = 1'b0;
    case (state_q)
      StBoot: begin
        if (!stall) begin
          pc_d       = pc_plus4;
          pc_id_d    = pc_q;
          valid_id_d = 1'b1;
        end
      end
      StRun: begin
        if (!stall) begin
          pc_d       = take_branch ? word_align(branch_target) : pc_plus4;
          pc_id_d    = pc_q;
          valid_id_d = 1'b1;
          misalign_d = take_branch && target_unaligned;
        end else if (take_branch) begin
          pend_d     = word_align(branch_target);
          misalign_d = target_unaligned;
        end
      end
      StPend: begin
        if (!stall) begin
          pc_d       = pend_q;
          pc_id_d    = pc_q;
          valid_id_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign imem_addr = pc_q;
  assign imem_en   = ~stall;
  assign pc_id     = pc_id_q;
  assign valid_id  = valid_id_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed vector table, hand-written
// wrap sequence, then random stimulus against a behavioural model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        take_branch;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] pc_id;
  logic [31:0] pc_id_plus8;
  logic        valid_id;
  logic        misalign;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .take_branch   (take_branch),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_en       (imem_en),
    .pc_id         (pc_id),
    .pc_id_plus8   (pc_id_plus8),
    .valid_id      (valid_id),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  // Behavioural model: what is being fetched, what sits in decode, and
  // whether a redirect is waiting for the stall to clear.
  logic [31:0] m_pc, m_pend, m_pc_id;
  bit          m_boot, m_pending, m_valid, m_mis;

  function automatic void model_edge(bit r, bit s, bit tb, logic [31:0] tgt);
    if (!r) begin
      m_pc = RST_PC; m_pend = 0; m_pending = 0; m_boot = 1;
      m_pc_id = 0; m_valid = 0; m_mis = 0;
      return;
    end
    m_mis = 0;
    if (m_boot) begin
      m_boot = 0;
      if (!s) begin m_pc_id = m_pc; m_valid = 1; m_pc = m_pc + 4; end
    end else if (m_pending) begin
      if (!s) begin m_pc_id = m_pc; m_valid = 1; m_pc = m_pend; m_pending = 0; end
    end else if (s) begin
      if (tb) begin
        m_pend = tgt - (tgt % 4); m_pending = 1; m_mis = (tgt % 4) != 0;
      end
    end else begin
      m_pc_id = m_pc; m_valid = 1;
      m_mis = tb && (tgt % 4) != 0;
      m_pc = tb ? tgt - (tgt % 4) : m_pc + 4;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Apply inputs, take one rising edge, advance the model, settle.
  task automatic step(input bit r, input bit s, input bit tb, input logic [31:0] tgt);
    rst_n = r; stall = s; take_branch = tb; branch_target = tgt;
    @(posedge clk);
    model_edge(r, s, tb, tgt);
    #1;
  endtask

  typedef struct {
    bit          r, s, tb;
    logic [31:0] tgt;
    logic [31:0] e_addr, e_pc_id;
    bit          e_valid, e_mis;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_n = 0; stall = 0; take_branch = 0; branch_target = 0;
    //           r  s  tb target         imem_addr     pc_id         v  mis
    vecs.push_back('{0, 0, 0, 32'h0,          32'h4000_0000, 32'h0,         0, 0});
    vecs.push_back('{1, 0, 0, 32'h0,          32'h4000_0004, 32'h4000_0000, 1, 0});
    vecs.push_back('{1, 0, 0, 32'h0,          32'h4000_0008, 32'h4000_0004, 1, 0});
    vecs.push_back('{1, 0, 0, 32'h0,          32'h4000_000C, 32'h4000_0008, 1, 0});
    vecs.push_back('{1, 0, 0, 32'h0,          32'h4000_0010, 32'h4000_000C, 1, 0});
    vecs.push_back('{1, 0, 1, 32'h4000_0100,  32'h4000_0100, 32'h4000_0010, 1, 0});
    vecs.push_back('{1, 0, 0, 32'h0,          32'h4000_0104, 32'h4000_0100, 1, 0});
    vecs.push_back('{1, 0, 1, 32'h4000_0303,  32'h4000_0300, 32'h4000_0104, 1, 1});
    vecs.push_back('{1, 0, 0, 32'h0,          32'h4000_0304, 32'h4000_0300, 1, 0});
    vecs.push_back('{1, 1, 1, 32'h4000_0200,  32'h4000_0304, 32'h4000_0300, 1, 0});
    vecs.push_back('{1, 1, 1, 32'h4000_0200,  32'h4000_0304, 32'h4000_0300, 1, 0});
    vecs.push_back('{1, 1, 1, 32'h4000_0200,  32'h4000_0304, 32'h4000_0300, 1, 0});
    vecs.push_back('{1, 0, 1, 32'h4000_0900,  32'h4000_0200, 32'h4000_0304, 1, 0});
    vecs.push_back('{1, 0, 0, 32'h0,          32'h4000_0204, 32'h4000_0200, 1, 0});
    vecs.push_back('{1, 1, 1, 32'h4000_0502,  32'h4000_0204, 32'h4000_0200, 1, 1});
    vecs.push_back('{1, 1, 1, 32'h4000_0500,  32'h4000_0204, 32'h4000_0200, 1, 0});
    vecs.push_back('{0, 1, 1, 32'h4000_0500,  32'h4000_0000, 32'h0,         0, 0});
    vecs.push_back('{0, 0, 0, 32'h0,          32'h4000_0000, 32'h0,         0, 0});
    vecs.push_back('{1, 0, 1, 32'h4000_0500,  32'h4000_0004, 32'h4000_0000, 1, 0});
    vecs.push_back('{1, 0, 0, 32'h0,          32'h4000_0008, 32'h4000_0004, 1, 0});

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].s, vecs[i].tb, vecs[i].tgt);
      check($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("vec%0d imem_en", i), imem_en, !vecs[i].s);
      check($sformatf("vec%0d pc_id", i), pc_id, vecs[i].e_pc_id);
      check($sformatf("vec%0d pc_id_plus8", i), pc_id_plus8, vecs[i].e_pc_id + 32'd8);
      check($sformatf("vec%0d valid_id", i), valid_id, vecs[i].e_valid);
      check($sformatf("vec%0d misalign", i), misalign, vecs[i].e_mis);
    end

    // Address wrap at the top of the 32-bit space.
    step(1, 0, 1, 32'hFFFF_FFFC);
    check("wrap branch imem_addr", imem_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 32'h0);
    check("wrap imem_addr", imem_addr, 32'h0000_0000);
    check("wrap pc_id", pc_id, 32'hFFFF_FFFC);
    check("wrap pc_id_plus8", pc_id_plus8, 32'h0000_0004);
    step(1, 0, 0, 32'h0);
    check("wrap next imem_addr", imem_addr, 32'h0000_0004);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r, s, tb;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 99) >= 2);
      s   = ($urandom_range(0, 99) < 30);
      tb  = ($urandom_range(0, 99) < 20);
      tgt = $urandom;
      step(r, s, tb, tgt);
      check("rnd imem_addr", imem_addr, m_pc);
      check("rnd imem_en", imem_en, !s);
      check("rnd pc_id", pc_id, m_pc_id);
      check("rnd pc_id_plus8", pc_id_plus8, m_pc_id + 32'd8);
      check("rnd valid_id", valid_id, m_valid);
      check("rnd misalign", misalign, m_mis);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
